cursor_paint_ctrl: RTL and testbench
====================================

Name: cursor_paint_ctrl

Overview:
Parametrised cursor/paint controller for the UART+BRAM+VGA frame-buffer system. It debounces four direction buttons and moves an (x,y) cursor with saturation at the screen edges. When painting is enabled, each accepted move writes the selected colour into the frame-buffer BRAM through a request/grant port. The external arbiter gives UART writes priority over this port. Cursor position is exported for the VGA overlay.

Parameters:
H_RES, 640, horizontal pixels; x range 0..H_RES-1
V_RES, 480, vertical pixels; y range 0..V_RES-1
X_W, 10, cursor_x width (ceil log2 H_RES)
Y_W, 9, cursor_y width (ceil log2 V_RES)
ADDR_W, 19, BRAM address width (ceil log2 H_RES*V_RES)
DATA_W, 8, BRAM data width
COLOR_W, 3, colour field width; must be <= DATA_W
STEP, 1, pixels moved per event; must be >= 1
DEBOUNCE_CYC, 50000, stable cycles needed before a key level is accepted (1 ms at 50 MHz)
REPEAT_DLY, 25000000, cycles held before auto-repeat starts (optional feature)
REPEAT_PER, 2500000, cycles between repeats (optional feature)

Ports:
clk  in  1  system clock, 50 MHz
reset_n  in  1  asynchronous, active-low reset
key_n  in  4  raw buttons, active low, asynchronous; [0]=up [1]=down [2]=left [3]=right
paint_en  in  1  level; 1 = paint on every accepted move
color  in  COLOR_W  colour to paint, sampled when the move is accepted
wr_gnt  in  1  arbiter grant; one-cycle pulse, accepts the current request
wr_req  out  1  write request, held high until granted
wr_addr  out  ADDR_W  y*H_RES + x of the painted pixel
wr_data  out  DATA_W  colour zero-extended to DATA_W
cursor_x  out  X_W  current x
cursor_y  out  Y_W  current y
busy  out  1  high while a write is pending

Behaviour:
- Clocking and reset: one clock; reset_n is asynchronous and active-low. While reset is asserted, all of the following are 0: cursor_x, cursor_y, wr_req, wr_addr, wr_data, busy. Synchronisers and debounce counters also clear, and the debounced key state clears to "released".
- Input path: each key_n bit goes through a 2-FF synchroniser, then a per-key counter. A new level is accepted only after DEBOUNCE_CYC consecutive equal samples. A press event is a one-cycle pulse on the released-to-pressed transition of the debounced level.
- Simultaneous events in the same cycle: exactly one is serviced, priority up > down > left > right. The others are dropped.
- Move arithmetic:
  - y_new = max(y-STEP, 0) for up; min(y+STEP, V_RES-1) for down. x follows the same rule for left/right with H_RES-1.
  - Arithmetic is done one bit wider than the operand so there is no wrap-around.
- Blocked moves: if the cursor is already at the boundary in the requested direction, the position is unchanged and no write is issued, even with paint_en=1.
- State machine IDLE -> MOVE -> REQ -> IDLE:
  - IDLE: on a press event, go to MOVE.
  - MOVE (1 cycle): update cursor_x/cursor_y. If paint_en=1 and the position changed, latch wr_addr = y_new*H_RES + x_new and wr_data = {0, color}, then go to REQ. Otherwise go to IDLE.
  - REQ: wr_req=1 and busy=1. When wr_gnt=1 is sampled, drop wr_req the next cycle and go to IDLE.
- Latency: press event at cycle N gives new position visible at N+2 and wr_req high at N+2.
- While in REQ: wr_addr and wr_data are stable. Press events arriving in MOVE or REQ are dropped, so no queueing occurs. There is no timeout on wr_gnt.
- Ignored signals: wr_gnt is ignored outside REQ. paint_en and color changes after MOVE do not affect a pending write.
- Reset mid-write: the pending write is abandoned, wr_req drops immediately, and the cursor returns to (0,0).

Optional Feature:
CURSOR_AUTOREPEAT_EN
- Defined: a key held debounced-pressed for REPEAT_DLY cycles generates a press event, then one more every REPEAT_PER cycles until release. Events go through the same priority and drop rules as normal presses. The repeat counters reset on release and on reset_n.
- Undefined: exactly one event per press, and no repeat counters are synthesised.

Decomposition:
- Shared package cursor_pkg holds:
  - state encoding IDLE/MOVE/REQ;
  - key index constants KEY_UP=0, KEY_DN=1, KEY_LF=2, KEY_RT=3;
  - a function computing ceil log2 for width checks.
- One sub-module, key_debounce: a single-key synchroniser, debounce counter and press-pulse generator, parameterised by DEBOUNCE_CYC. It holds the repeat logic under the macro and is instantiated four times.

Test Plan:
(bench uses DEBOUNCE_CYC=4, REPEAT_DLY=40, REPEAT_PER=10)
- Reset, then press key_n[1] (down) for 20 cycles with paint_en=0 -> cursor=(0,1); wr_req never asserts.
- Press key_n[3] (right) with paint_en=1, color=3'b111, wr_gnt tied high -> cursor=(1,1); one write with wr_addr=641, wr_data=8'h07; wr_req high for exactly 1 cycle.
- At (0,0), press up then left with paint_en=1 -> position stays (0,0); no wr_req.
- Press down 500 times -> cursor_y saturates at 479; cursor_x is unchanged.
- Hold wr_gnt=0 for 100 cycles during REQ and press right again -> wr_req and wr_addr stay stable; the second press is dropped; after the grant, cursor_x advanced by only 1.
- Glitch of 2 cycles on key_n[0] -> no move. Up and right pressed together -> only y changes. Assert reset_n low during REQ -> wr_req=0 asynchronously and cursor=(0,0).

Source files
------------

// File: rtl/cursor_pkg.sv
// Shared definitions for the cursor/paint controller: FSM states, key indices
// and a ceil-log2 helper used for counter sizing and parameter sanity checks.
package cursor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    REQ  = 2'd2
  } state_t;

  localparam int KEY_UP = 0;
  localparam int KEY_DN = 1;
  localparam int KEY_LF = 2;
  localparam int KEY_RT = 3;

  function automatic int clog2(input int v);
    int     r;
    longint p;
    r = 0;
    p = 1;
    while (p < longint'(v)) begin
      p = p * 2;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One button: 2-FF synchroniser, debounce counter and press pulse.
// Auto-repeat is compiled in only when CURSOR_AUTOREPEAT_EN is defined.
module key_debounce
  import cursor_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 50000
`ifdef CURSOR_AUTOREPEAT_EN
  , parameter int REPEAT_DLY = 25000000
  , parameter int REPEAT_PER = 2500000
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = clog2(DEBOUNCE_CYC + 1);

  logic [1:0]       sync;
  logic             lvl;
  logic [CNT_W-1:0] cnt;
  logic             smp;
  logic             accept;
  logic             rep_hit;

  // lvl is the debounced "pressed" level; the button itself is active low
  assign smp    = ~sync[1];
  assign accept = (smp != lvl) && (cnt == CNT_W'(DEBOUNCE_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= 2'b11;
      lvl   <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], key_n};
      press <= (accept & smp) | rep_hit;
      if (smp == lvl) begin
        cnt <= '0;
      end else if (accept) begin
        cnt <= '0;
        lvl <= smp;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef CURSOR_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int RCNT_W  = clog2(RPT_MAX + 1);

  logic [RCNT_W-1:0] rcnt;
  logic              rep_run;

  // first repeat after REPEAT_DLY held cycles, then one every REPEAT_PER
  assign rep_hit = lvl && (rep_run ? (rcnt == RCNT_W'(REPEAT_PER - 1))
                                   : (rcnt == RCNT_W'(REPEAT_DLY - 1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt    <= '0;
      rep_run <= 1'b0;
    end else if (!lvl) begin
      rcnt    <= '0;
      rep_run <= 1'b0;
    end else if (rep_hit) begin
      rcnt    <= '0;
      rep_run <= 1'b1;
    end else begin
      rcnt <= rcnt + 1'b1;
    end
  end
`else
  assign rep_hit = 1'b0;
`endif

endmodule

// File: rtl/cursor_paint_ctrl.sv
// Cursor/paint controller: four debounced keys move a saturating cursor and,
// with paint_en, each real move posts one BRAM write. Macro: CURSOR_AUTOREPEAT_EN.
module cursor_paint_ctrl
  import cursor_pkg::*;
#(
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int X_W          = 10,
  parameter int Y_W          = 9,
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 8,
  parameter int COLOR_W      = 3,
  parameter int STEP         = 1,
  parameter int DEBOUNCE_CYC = 50000,
  parameter int REPEAT_DLY   = 25000000,
  parameter int REPEAT_PER   = 2500000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [3:0]         key_n,
  input  logic               paint_en,
  input  logic [COLOR_W-1:0] color,
  input  logic               wr_gnt,
  output logic               wr_req,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [DATA_W-1:0]  wr_data,
  output logic [X_W-1:0]     cursor_x,
  output logic [Y_W-1:0]     cursor_y,
  output logic               busy
);

  if (X_W < clog2(H_RES) || Y_W < clog2(V_RES) || ADDR_W < clog2(H_RES * V_RES) ||
      COLOR_W > DATA_W || STEP < 1 || DEBOUNCE_CYC < 1 ||
      REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_param_err
    $error("cursor_paint_ctrl: inconsistent parameters");
  end

  logic [3:0] press;

  for (genvar k = 0; k < 4; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
`ifdef CURSOR_AUTOREPEAT_EN
      , .REPEAT_DLY(REPEAT_DLY)
      , .REPEAT_PER(REPEAT_PER)
`endif
    ) u_key (
      .clk   (clk),
      .rst_n (reset_n),
      .key_n (key_n[k]),
      .press (press[k])
    );
  end

  state_t      state;
  logic [3:0]  dir;
  logic [3:0]  sel;
  logic [X_W:0] x_inc, x_dec;
  logic [Y_W:0] y_inc, y_dec;
  logic [X_W-1:0] x_new;
  logic [Y_W-1:0] y_new;
  logic         moved;
  logic [ADDR_W-1:0] addr_new;

  // simultaneous events: keep only the highest-priority one
  always_comb begin
    sel = '0;
    if      (press[KEY_UP]) sel[KEY_UP] = 1'b1;
    else if (press[KEY_DN]) sel[KEY_DN] = 1'b1;
    else if (press[KEY_LF]) sel[KEY_LF] = 1'b1;
    else if (press[KEY_RT]) sel[KEY_RT] = 1'b1;
  end

  // one extra bit: borrow flags underflow, overflow compares against the edge
  always_comb begin
    x_inc = {1'b0, cursor_x} + (X_W+1)'(STEP);
    x_dec = {1'b0, cursor_x} - (X_W+1)'(STEP);
    y_inc = {1'b0, cursor_y} + (Y_W+1)'(STEP);
    y_dec = {1'b0, cursor_y} - (Y_W+1)'(STEP);
    x_new = cursor_x;
    y_new = cursor_y;
    if (dir[KEY_UP]) y_new = y_dec[Y_W] ? '0 : y_dec[Y_W-1:0];
    if (dir[KEY_DN]) y_new = (y_inc > (Y_W+1)'(V_RES - 1)) ? Y_W'(V_RES - 1) : y_inc[Y_W-1:0];
    if (dir[KEY_LF]) x_new = x_dec[X_W] ? '0 : x_dec[X_W-1:0];
    if (dir[KEY_RT]) x_new = (x_inc > (X_W+1)'(H_RES - 1)) ? X_W'(H_RES - 1) : x_inc[X_W-1:0];
    moved    = (x_new != cursor_x) || (y_new != cursor_y);
    addr_new = ADDR_W'(y_new) * ADDR_W'(H_RES) + ADDR_W'(x_new);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      dir      <= '0;
      cursor_x <= '0;
      cursor_y <= '0;
      wr_req   <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|press) begin
            dir   <= sel;
            state <= MOVE;
          end
        end
        MOVE: begin
          cursor_x <= x_new;
          cursor_y <= y_new;
          if (paint_en && moved) begin
            wr_addr <= addr_new;
            wr_data <= DATA_W'(color);
            wr_req  <= 1'b1;
            busy    <= 1'b1;
            state   <= REQ;
          end else begin
            state <= IDLE;
          end
        end
        REQ: begin
          if (wr_gnt) begin
            wr_req <= 1'b0;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cursor_paint_ctrl.sv
// Self-checking bench for cursor_paint_ctrl: a directed vector table, hand
// sequences for stalls/saturation/reset, and random presses against a model.
module tb_cursor_paint_ctrl;

  localparam int H_RES = 640, V_RES = 480, X_W = 10, Y_W = 9, ADDR_W = 19;
  localparam int DATA_W = 8, COLOR_W = 3, STEP = 1;
  localparam int DB = 4, RDLY = 40, RPER = 10;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic [3:0]         key_n = 4'hF;
  logic               paint_en = 1'b0;
  logic [COLOR_W-1:0] color = '0;
  logic               wr_gnt = 1'b0;
  logic               wr_req;
  logic [ADDR_W-1:0]  wr_addr;
  logic [DATA_W-1:0]  wr_data;
  logic [X_W-1:0]     cursor_x;
  logic [Y_W-1:0]     cursor_y;
  logic               busy;

  always #5 clk = ~clk;

  cursor_paint_ctrl #(
    .H_RES(H_RES), .V_RES(V_RES), .X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W),
    .DATA_W(DATA_W), .COLOR_W(COLOR_W), .STEP(STEP),
    .DEBOUNCE_CYC(DB), .REPEAT_DLY(RDLY), .REPEAT_PER(RPER)
  ) dut (
    .clk(clk), .reset_n(reset_n), .key_n(key_n), .paint_en(paint_en),
    .color(color), .wr_gnt(wr_gnt), .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data), .cursor_x(cursor_x), .cursor_y(cursor_y), .busy(busy)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t obs[$];
  int  checks = 0;
  int  fails = 0;
  int  stab_err = 0;
  int  run_len = 0;
  int  last_run = 0;
  int  gnt_mode = 1;   // 0 hold low, 1 tied high, 2 random
  int  mx = 0, my = 0; // model cursor

  // grant driver, changes just after the active edge
  initial forever begin
    @(posedge clk);
    #2;
    case (gnt_mode)
      0:       wr_gnt = 1'b0;
      1:       wr_gnt = 1'b1;
      default: wr_gnt = ($urandom_range(0, 2) == 0);
    endcase
  end

  // write monitor: records granted writes, request length and stability
  initial begin
    logic             prev_req;
    logic [ADDR_W-1:0] prev_addr;
    logic [DATA_W-1:0] prev_data;
    prev_req = 1'b0; prev_addr = '0; prev_data = '0;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (wr_req && wr_gnt) obs.push_back({wr_addr, wr_data});
        if (busy !== wr_req) stab_err++;
        if (wr_req && prev_req && (wr_addr !== prev_addr || wr_data !== prev_data)) stab_err++;
        if (wr_req) run_len++;
        else if (run_len != 0) begin
          last_run = run_len;
          run_len  = 0;
        end
      end else begin
        run_len = 0;
      end
      prev_req = wr_req; prev_addr = wr_addr; prev_data = wr_data;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_x", cursor_x, 0);
    chk("rst_y", cursor_y, 0);
    chk("rst_req", wr_req, 0);
    chk("rst_addr", wr_addr, 0);
    chk("rst_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    mx = 0; my = 0;
    obs.delete();
    @(negedge clk);
  endtask

  task automatic press(input logic [3:0] m, input int hold, input bit wait_idle);
    int n;
    @(negedge clk);
    key_n = ~m;
    repeat (hold) @(negedge clk);
    key_n = 4'hF;
    repeat (12) @(negedge clk);
    if (wait_idle) begin
      n = 0;
      while (wr_req && n < 300) begin
        @(negedge clk);
        n++;
      end
      if (wr_req) begin
        checks++;
        fails++;
        $display("FAIL grant_wait: wr_req=%0d after %0d cycles, required 0", wr_req, n);
      end
      repeat (3) @(negedge clk);
    end
  endtask

  // behavioural model: one event per long-enough press, priority U>D>L>R, saturate
  task automatic model(input logic [3:0] m, input int hold, input bit pe,
                       output int ex, output int ey, output bit ew);
    int nx, ny;
    nx = mx; ny = my;
    if (hold >= DB + 2) begin
      if      (m[0]) ny = (my - STEP < 0) ? 0 : my - STEP;
      else if (m[1]) ny = (my + STEP > V_RES - 1) ? V_RES - 1 : my + STEP;
      else if (m[2]) nx = (mx - STEP < 0) ? 0 : mx - STEP;
      else if (m[3]) nx = (mx + STEP > H_RES - 1) ? H_RES - 1 : mx + STEP;
    end
    ew = pe && (nx != mx || ny != my);
    mx = nx; my = ny;
    ex = nx; ey = ny;
  endtask

  task automatic apply(input string nm, input logic [3:0] m, input int hold,
                       input logic pe, input int c, input int ex, input int ey,
                       input bit ew, input int ea, input int ed, input bit chk_run);
    int n0;
    paint_en = pe;
    color    = COLOR_W'(c);
    n0       = obs.size();
    press(m, hold, 1'b1);
    chk({nm, "_x"}, cursor_x, ex);
    chk({nm, "_y"}, cursor_y, ey);
    chk({nm, "_nwr"}, obs.size() - n0, ew);
    if (ew && obs.size() > n0) begin
      chk({nm, "_addr"}, obs[n0].addr, ea);
      chk({nm, "_data"}, obs[n0].data, ed);
      if (chk_run) chk({nm, "_reqlen"}, last_run, 1);
    end
  endtask

  typedef struct {
    bit         rst;
    logic [3:0] m;
    int         hold;
    bit         pe;
    int         c;
    int         ex, ey;
    bit         ew;
    int         ea, ed;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int ex, ey, n0;
    bit ew;
    logic [3:0] m;
    int hold, c;
    bit pe;

    //           rst  mask     hold pe c  x  y  w  addr data
    tbl[0] = '{1'b1, 4'b0010, 20, 1'b0, 0, 0, 1, 1'b0, 0,   0};
    tbl[1] = '{1'b0, 4'b1000,  8, 1'b1, 7, 1, 1, 1'b1, 641, 7};
    tbl[2] = '{1'b1, 4'b0001,  8, 1'b1, 5, 0, 0, 1'b0, 0,   0};
    tbl[3] = '{1'b0, 4'b0100,  8, 1'b1, 5, 0, 0, 1'b0, 0,   0};
    tbl[4] = '{1'b0, 4'b1000,  8, 1'b1, 2, 1, 0, 1'b1, 1,   2};
    tbl[5] = '{1'b0, 4'b0010,  8, 1'b1, 4, 1, 1, 1'b1, 641, 4};
    tbl[6] = '{1'b0, 4'b0001,  2, 1'b1, 1, 1, 1, 1'b0, 0,   0};
    tbl[7] = '{1'b0, 4'b0100,  8, 1'b0, 3, 0, 1, 1'b0, 0,   0};
    tbl[8] = '{1'b0, 4'b1001,  8, 1'b1, 6, 0, 0, 1'b1, 0,   6};

    gnt_mode = 1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].rst) do_reset();
      apply($sformatf("vec%0d", i), tbl[i].m, tbl[i].hold, tbl[i].pe, tbl[i].c,
            tbl[i].ex, tbl[i].ey, tbl[i].ew, tbl[i].ea, tbl[i].ed, 1'b1);
      mx = tbl[i].ex;
      my = tbl[i].ey;
    end

    // random presses, single keys and combinations, with random grant delay
    gnt_mode = 2;
    for (int i = 0; i < 120; i++) begin
      m    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15))
                                         : 4'(1 << $urandom_range(0, 3));
      hold = ($urandom_range(0, 7) == 0) ? 2 : 8;
      pe   = 1'($urandom_range(0, 1));
      c    = $urandom_range(0, 7);
      model(m, hold, pe, ex, ey, ew);
      apply("rnd", m, hold, pe, c, ex, ey, ew, ey * H_RES + ex, c, 1'b0);
    end

    // saturation at the bottom edge
    gnt_mode = 1;
    paint_en = 1'b0;
    for (int i = 0; i < 500; i++) press(4'b0010, 8, 1'b1);
    chk("sat_y", cursor_y, V_RES - 1);
    chk("sat_x", cursor_x, mx);
    my = V_RES - 1;
    model(4'b0010, 8, 1'b1, ex, ey, ew);
    apply("sat_blocked", 4'b0010, 8, 1'b1, 5, ex, ey, ew, 0, 0, 1'b1);

    // up+right together: only y moves
    model(4'b1001, 8, 1'b1, ex, ey, ew);
    apply("combo", 4'b1001, 8, 1'b1, 3, ex, ey, ew, ey * H_RES + ex, 3, 1'b1);

    // stalled grant: request holds, second press is dropped
    gnt_mode = 0;
    paint_en = 1'b1;
    color    = 3'd5;
    model(4'b1000, 8, 1'b1, ex, ey, ew);
    n0 = obs.size();
    press(4'b1000, 8, 1'b0);
    chk("stall_req", wr_req, 1);
    chk("stall_addr", wr_addr, ey * H_RES + ex);
    chk("stall_data", wr_data, 5);
    color = 3'd2;
    press(4'b1000, 8, 1'b0);
    repeat (70) @(negedge clk);
    chk("stall_req_hold", wr_req, 1);
    chk("stall_addr_hold", wr_addr, ey * H_RES + ex);
    chk("stall_data_hold", wr_data, 5);
    chk("stall_x", cursor_x, ex);
    gnt_mode = 1;
    repeat (5) @(negedge clk);
    chk("stall_nwr", obs.size() - n0, 1);
    chk("stall_x_after", cursor_x, ex);
    chk("stall_req_drop", wr_req, 0);

    // reset while a write is pending
    gnt_mode = 0;
    press(4'b1000, 8, 1'b0);
    chk("rst_req_pre", wr_req, 1);
    @(posedge clk);
    #3;
    do_reset();
    gnt_mode = 1;

    chk("monitor_stable", stab_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
